moving_avg_filter_var: RTL and testbench

- Dual-channel (SIN/COS) moving-sum filter with a runtime-variable window of DELAY+1 samples.
- Sits directly upstream of the filter auto-scale control:
  - it feeds that block TOP_SIN, TOP_COS and UPDATE;
  - it consumes the DELAY value that block produces.
- Full-width sums are also exported for the downstream phase/amplitude path.

---
 rtl/moving_avg_filter_var_pkg.sv | 20 ++
 rtl/moving_avg_filter_var_if.sv | 39 +++
 rtl/moving_avg_filter_var_sample_ring_buffer.sv | 35 +++
 rtl/moving_avg_filter_var.sv | 108 ++++++++++
 tb/tb_moving_avg_filter_var.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/moving_avg_filter_var_pkg.sv
// Shared definitions for the variable-window moving-sum filter.
//   acc_bits()         : width of a full window sum for a given sample width
//                        and window-code width (one guard bit per doubling of
//                        the ring depth, so the sum can never overflow).
//   TOP_BITS_DEFAULT   : width of the signed top slices handed to the
//                        auto-scale control block; both blocks use this value.
//   top_lsb()          : bit index of the lowest bit of a top slice.
package moving_avg_filter_var_pkg;

   localparam int TOP_BITS_DEFAULT = 4;

   function automatic int acc_bits(input int data_bits, input int delay_bits);
      return data_bits + delay_bits;
   endfunction

   function automatic int top_lsb(input int acc_w, input int top_w);
      return acc_w - top_w;
   endfunction

endpackage

// File: rtl/moving_avg_filter_var_if.sv
// Sample/result bundle of the moving-sum filter.
//   master : drives CE, IN_SIN, IN_COS, DELAY; observes the results.
//   slave  : the filter; drives OUT_SIN, OUT_COS, TOP_SIN, TOP_COS, VALID,
//            UPDATE.
// Handshake: a sample is consumed on every CLK edge with CE=1 (no
// back-pressure). Results for that sample are visible right after the same
// edge. VALID=1 means the current sums cover a fully populated window.
// UPDATE is held from one CE edge to the next, so CE&UPDATE marks exactly one
// sample per window for the auto-scale control.
interface moving_avg_filter_var_if
   import moving_avg_filter_var_pkg::*;
#(
   parameter int DATA_BITS     = 12,
   parameter int DELAY_BITS    = 4,
   parameter int TOP_DATA_BITS = TOP_BITS_DEFAULT
);
   localparam int ACC_BITS = acc_bits(DATA_BITS, DELAY_BITS);

   logic                             CE;
   logic signed [DATA_BITS-1:0]      IN_SIN;
   logic signed [DATA_BITS-1:0]      IN_COS;
   logic        [DELAY_BITS-1:0]     DELAY;
   logic signed [ACC_BITS-1:0]       OUT_SIN;
   logic signed [ACC_BITS-1:0]       OUT_COS;
   logic signed [TOP_DATA_BITS-1:0]  TOP_SIN;
   logic signed [TOP_DATA_BITS-1:0]  TOP_COS;
   logic                             VALID;
   logic                             UPDATE;

   modport master (
      output CE, IN_SIN, IN_COS, DELAY,
      input  OUT_SIN, OUT_COS, TOP_SIN, TOP_COS, VALID, UPDATE
   );

   modport slave (
      input  CE, IN_SIN, IN_COS, DELAY,
      output OUT_SIN, OUT_COS, TOP_SIN, TOP_COS, VALID, UPDATE
   );
endinterface

// File: rtl/moving_avg_filter_var_sample_ring_buffer.sv
// Two-channel sample ring (distributed RAM style).
//   CLK                : clock
//   WE, WADDR          : synchronous write of WDATA_SIN/WDATA_COS
//   RADDR              : asynchronous read address
//   RDATA_SIN/RDATA_COS: contents at RADDR before any write on this edge
// No reset: every location is written before the filter ever reads it.
module sample_ring_buffer #(
   parameter int DATA_BITS = 12,
   parameter int ADDR_BITS = 4
) (
   input  logic                  CLK,
   input  logic                  WE,
   input  logic [ADDR_BITS-1:0]  WADDR,
   input  logic [DATA_BITS-1:0]  WDATA_SIN,
   input  logic [DATA_BITS-1:0]  WDATA_COS,
   input  logic [ADDR_BITS-1:0]  RADDR,
   output logic [DATA_BITS-1:0]  RDATA_SIN,
   output logic [DATA_BITS-1:0]  RDATA_COS
);
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_BITS-1:0] mem_sin [DEPTH];
   logic [DATA_BITS-1:0] mem_cos [DEPTH];

   always_ff @(posedge CLK) begin
      if (WE) begin
         mem_sin[WADDR] <= WDATA_SIN;
         mem_cos[WADDR] <= WDATA_COS;
      end
   end

   // Combinational read sees the old word even when RADDR == WADDR.
   assign RDATA_SIN = mem_sin[RADDR];
   assign RDATA_COS = mem_cos[RADDR];
endmodule

// File: rtl/moving_avg_filter_var.sv
// Dual-channel (SIN/COS) moving-sum filter, window = DELAY+1 samples.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : slave side of moving_avg_filter_var_if
//                (CE, IN_SIN, IN_COS, DELAY in; OUT_SIN, OUT_COS, TOP_SIN,
//                 TOP_COS, VALID, UPDATE out)
// A change of DELAY on a CE cycle restarts the window from that sample.
module moving_avg_filter_var
   import moving_avg_filter_var_pkg::*;
#(
   parameter int DATA_BITS     = 12,
   parameter int DELAY_BITS    = 4,
   parameter int TOP_DATA_BITS = TOP_BITS_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RESET,
   moving_avg_filter_var_if.slave bus
);
   localparam int ACC_BITS = acc_bits(DATA_BITS, DELAY_BITS);

   logic signed [ACC_BITS-1:0]   acc_sin, acc_cos;
   logic        [DELAY_BITS-1:0] wr_ptr, rd_addr, delay_q, period;
   logic        [DELAY_BITS:0]   fill, window;
   logic                         valid_q, update_q;
   logic        [DATA_BITS-1:0]  old_sin, old_cos;
   logic signed [ACC_BITS-1:0]   in_sin_ext, in_cos_ext, old_sin_ext, old_cos_ext;
   logic                         restart, window_full, fill_done;

   sample_ring_buffer #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (DELAY_BITS)
   ) u_ring (
      .CLK       (CLK),
      .WE        (bus.CE & ~RESET),
      .WADDR     (wr_ptr),
      .WDATA_SIN (bus.IN_SIN),
      .WDATA_COS (bus.IN_COS),
      .RADDR     (rd_addr),
      .RDATA_SIN (old_sin),
      .RDATA_COS (old_cos)
   );

   // Oldest sample of the window; with the deepest window this is wr_ptr
   // itself and the ring returns the word about to be overwritten.
   assign rd_addr     = wr_ptr - delay_q - DELAY_BITS'(1);
   assign window      = {1'b0, delay_q} + (DELAY_BITS+1)'(1);
   assign restart     = (bus.DELAY != delay_q);
   assign window_full = (fill == window);
   assign fill_done   = ((fill + (DELAY_BITS+1)'(1)) == window);

   assign in_sin_ext  = {{DELAY_BITS{bus.IN_SIN[DATA_BITS-1]}}, bus.IN_SIN};
   assign in_cos_ext  = {{DELAY_BITS{bus.IN_COS[DATA_BITS-1]}}, bus.IN_COS};
   assign old_sin_ext = {{DELAY_BITS{old_sin[DATA_BITS-1]}}, old_sin};
   assign old_cos_ext = {{DELAY_BITS{old_cos[DATA_BITS-1]}}, old_cos};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc_sin  <= '0;
         acc_cos  <= '0;
         wr_ptr   <= '0;
         fill     <= '0;
         period   <= '0;
         valid_q  <= 1'b0;
         update_q <= 1'b0;
         delay_q  <= bus.DELAY;
      end else if (bus.CE) begin
         wr_ptr <= wr_ptr + DELAY_BITS'(1);
         if (restart) begin
            // New window length: this sample becomes the first of the window.
            delay_q  <= bus.DELAY;
            acc_sin  <= in_sin_ext;
            acc_cos  <= in_cos_ext;
            fill     <= (DELAY_BITS+1)'(1);
            valid_q  <= 1'b0;
            period   <= '0;
            update_q <= 1'b0;
         end else if (window_full) begin
            acc_sin <= acc_sin + in_sin_ext - old_sin_ext;
            acc_cos <= acc_cos + in_cos_ext - old_cos_ext;
            if (period == delay_q) begin
               period   <= '0;
               update_q <= 1'b1;
            end else begin
               period   <= period + DELAY_BITS'(1);
               update_q <= 1'b0;
            end
         end else begin
            acc_sin <= acc_sin + in_sin_ext;
            acc_cos <= acc_cos + in_cos_ext;
            fill    <= fill + (DELAY_BITS+1)'(1);
            // The edge that completes the window counts as period slot 0.
            if (fill_done) begin
               valid_q  <= 1'b1;
               update_q <= 1'b1;
               period   <= '0;
            end else begin
               update_q <= 1'b0;
            end
         end
      end
   end

   assign bus.OUT_SIN = acc_sin;
   assign bus.OUT_COS = acc_cos;
   assign bus.TOP_SIN = acc_sin[ACC_BITS-1 -: TOP_DATA_BITS];
   assign bus.TOP_COS = acc_cos[ACC_BITS-1 -: TOP_DATA_BITS];
   assign bus.VALID   = valid_q;
   assign bus.UPDATE  = update_q;
endmodule

// File: tb/tb_moving_avg_filter_var.sv
// Directed bench for moving_avg_filter_var (DATA_BITS=12, DELAY_BITS=4).
// Each driven cycle pushes the expected post-edge result word; the monitor
// pops one word per clock edge and compares it with the DUT.
module tb_moving_avg_filter_var;
   localparam int W = 42; // {out_sin16, out_cos16, top_sin4, top_cos4, valid, update}

   logic CLK;
   logic RESET;

   moving_avg_filter_var_if bus_if ();

   moving_avg_filter_var dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus_if.slave)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: time limit reached, required end of test");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic         mon_en   = 1'b0;

   // ---------------- driver ----------------
   task automatic step(input logic rst, input logic ce, input int sin, input int cos,
                       input int dly, input int e_sin, input int e_cos,
                       input logic e_valid, input logic e_upd, input string tag);
      logic [15:0] es, ec;
      @(negedge CLK);
      RESET         = rst;
      bus_if.CE     = ce;
      bus_if.IN_SIN = 12'(sin);
      bus_if.IN_COS = 12'(cos);
      bus_if.DELAY  = 4'(dly);
      es = 16'(e_sin);
      ec = 16'(e_cos);
      exp_q.push_back({es, ec, es[15:12], ec[15:12], e_valid, e_upd});
      tag_q.push_back(tag);
      mon_en = 1'b1;
   endtask

   task automatic do_reset(input int dly);
      step(1'b1, 1'b1, 0, 0, dly, 0, 0, 1'b0, 1'b0, "reset");
   endtask

   // ---------------- monitor ----------------
   always @(posedge CLK) begin
      if (mon_en) begin
         logic [W-1:0] act, exp;
         string        tag;
         #1;
         act = {bus_if.OUT_SIN, bus_if.OUT_COS, bus_if.TOP_SIN, bus_if.TOP_COS,
                bus_if.VALID, bus_if.UPDATE};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expected: output at %0t with empty queue", $time);
         end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            if (act !== exp) begin
               n_fail++;
               $display("FAIL %s @%0t: got sin=%0d cos=%0d top=%h/%h v=%b u=%b, required sin=%0d cos=%0d top=%h/%h v=%b u=%b",
                        tag, $time,
                        $signed(act[41:26]), $signed(act[25:10]), act[9:6], act[5:2], act[1], act[0],
                        $signed(exp[41:26]), $signed(exp[25:10]), exp[9:6], exp[5:2], exp[1], exp[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      RESET         = 1'b1;
      bus_if.CE     = 1'b0;
      bus_if.IN_SIN = '0;
      bus_if.IN_COS = '0;
      bus_if.DELAY  = '0;

      // 1: constant input, window 4
      do_reset(3);
      for (int k = 1; k <= 12; k++) begin
         int m;
         m = (k < 4) ? k : 4;
         step(1'b0, 1'b1, 100, -50, 3, m * 100, m * -50, k >= 4, (k % 4) == 0, "s1_const");
      end

      // 2: step response 0 -> 1000 after VALID
      do_reset(3);
      for (int k = 1; k <= 4; k++)
         step(1'b0, 1'b1, 0, 0, 3, 0, 0, k == 4, k == 4, "s2_zero");
      step(1'b0, 1'b1, 1000, 0, 3, 1000, 0, 1'b1, 1'b0, "s2_step");
      step(1'b0, 1'b1, 1000, 0, 3, 2000, 0, 1'b1, 1'b0, "s2_step");
      step(1'b0, 1'b1, 1000, 0, 3, 3000, 0, 1'b1, 1'b0, "s2_step");
      step(1'b0, 1'b1, 1000, 0, 3, 4000, 0, 1'b1, 1'b1, "s2_step");
      step(1'b0, 1'b1, 1000, 0, 3, 4000, 0, 1'b1, 1'b0, "s2_hold");
      step(1'b0, 1'b1, 1000, 0, 3, 4000, 0, 1'b1, 1'b0, "s2_hold");
      step(1'b0, 1'b1, 1000, 0, 3, 4000, 0, 1'b1, 1'b0, "s2_hold");
      step(1'b0, 1'b1, 1000, 0, 3, 4000, 0, 1'b1, 1'b1, "s2_hold");

      // 3: full-depth window, extreme values, rd == wr old-value read
      do_reset(15);
      for (int k = 1; k <= 16; k++)
         step(1'b0, 1'b1, -2048, 2047, 15, -2048 * k, 2047 * k, k == 16, k == 16, "s3_fill");
      step(1'b0, 1'b1, 2047, -2048, 15, -28673, 28657, 1'b1, 1'b0, "s3_oldread");

      // 4: DELAY change 3 -> 7 mid-stream
      do_reset(3);
      for (int k = 1; k <= 6; k++) begin
         int m;
         m = (k < 4) ? k : 4;
         step(1'b0, 1'b1, 10, 10, 3, m * 10, m * 10, k >= 4, k == 4, "s4_win4");
      end
      step(1'b0, 1'b1, 10, 10, 7, 10, 10, 1'b0, 1'b0, "s4_restart");
      for (int k = 2; k <= 8; k++)
         step(1'b0, 1'b1, 10, 10, 7, k * 10, k * 10, k == 8, k == 8, "s4_refill");
      for (int k = 9; k <= 16; k++)
         step(1'b0, 1'b1, 10, 10, 7, 80, 80, 1'b1, k == 16, "s4_win8");

      // 5: CE gating; DELAY/input changes while CE=0 must be ignored
      do_reset(3);
      for (int k = 1; k <= 12; k++) begin
         int m;
         m = (k < 4) ? k : 4;
         step(1'b0, 1'b1, 100, -50, 3, m * 100, m * -50, k >= 4, (k % 4) == 0, "s5_ce");
         step(1'b0, 1'b0, 777, 123, 7, m * 100, m * -50, k >= 4, (k % 4) == 0, "s5_hold");
      end

      // 6: RESET mid-window (fill=2), RESET asserted together with CE
      do_reset(3);
      step(1'b0, 1'b1, 100, -50, 3, 100, -50, 1'b0, 1'b0, "s6_pre");
      step(1'b0, 1'b1, 100, -50, 3, 200, -100, 1'b0, 1'b0, "s6_pre");
      step(1'b1, 1'b1, 100, -50, 3, 0, 0, 1'b0, 1'b0, "s6_reset");
      for (int k = 1; k <= 8; k++) begin
         int m;
         m = (k < 4) ? k : 4;
         step(1'b0, 1'b1, 100, -50, 3, m * 100, m * -50, k >= 4, (k % 4) == 0, "s6_refill");
      end

      // drain
      @(posedge CLK);
      #3;
      mon_en = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
